// File: rtl/spi_pkg.sv
// Shared SPI constants used by spi_target and spi_controller.
// Keeps CRC polynomial and idle byte matched on both ends of the link.
package spi_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'h0000;
  localparam logic [7:0]  IDLE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/crc16_bit.sv
// Single-bit CRC16-CCITT step, MSB first, no reflection.
// Shared by the SPI target and controller.
module crc16_bit
  import spi_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic fb;

  assign fb    = crc_i[15] ^ bit_i;
  assign crc_o = {crc_i[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled by clk, with one-entry tx holding
// register, sticky underrun flag and running CRC16 on received bits.
module spi_target
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        _ss,
  output logic        miso,
  output logic        miso_oe,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        crc_clr,
  output logic [15:0] crc,
  output logic        tx_underrun,
  input  logic        underrun_clr
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic sclk_s;
  logic mosi_s;
  logic ss_s;
  logic sel;
  logic rise;
  logic fall;
  logic ss_fall;
  logic ss_rise;
  logic load;

  logic [2:0]  bitcnt_q,  bitcnt_d;
  logic [6:0]  rx_sr_q,   rx_sr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_vld_q,  rx_vld_d;
  logic [15:0] crc_q,     crc_d;
  logic [15:0] crc_nxt;
  logic [7:0]  tx_sr_q,   tx_sr_d;
  logic [7:0]  hold_q,    hold_d;
  logic        full_q,    full_d;
  logic        unr_q,     unr_d;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q[0] <= sclk;
      mosi_sync_q[0] <= mosi;
      ss_sync_q[0]   <= _ss;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        ss_sync_q[i]   <= ss_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign sel     = ~ss_s;
  assign rise    = sel & sclk_s & ~sclk_prev_q;
  assign fall    = sel & ~sclk_s & sclk_prev_q;
  assign ss_fall = ss_prev_q & ~ss_s;
  assign ss_rise = ~ss_prev_q & ss_s;
  // Next byte goes out at select and at each byte boundary.
  assign load    = ss_fall | (fall & (bitcnt_q == 3'd0));

  crc16_bit u_crc (
    .crc_i (crc_q),
    .bit_i (mosi_s),
    .crc_o (crc_nxt)
  );

  always_comb begin
    bitcnt_d  = bitcnt_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    crc_d     = crc_q;
    tx_sr_d   = tx_sr_q;
    hold_d    = hold_q;
    full_d    = full_q;
    unr_d     = unr_q;

    if (rise) begin
      rx_sr_d  = {rx_sr_q[5:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      crc_d    = crc_nxt;
      if (bitcnt_q == 3'd7) begin
        rx_data_d = {rx_sr_q, mosi_s};
        rx_vld_d  = 1'b1;
      end
    end
    if (ss_rise) bitcnt_d = 3'd0;
    if (crc_clr) crc_d = CRC16_INIT;

    if (load) begin
      if (full_q) begin
        tx_sr_d = hold_q;
        full_d  = 1'b0;
      end else begin
        tx_sr_d = IDLE_BYTE;
        unr_d   = 1'b1;
      end
    end else if (fall) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end

    // Offer is gated by the registered ready, so a same-cycle load
    // of an empty holder and a new accept both land.
    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
    if (underrun_clr) unr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      bitcnt_q  <= 3'd0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      crc_q     <= CRC16_INIT;
      tx_sr_q   <= IDLE_BYTE;
      hold_q    <= '0;
      full_q    <= 1'b0;
      unr_q     <= 1'b0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      crc_q     <= crc_d;
      tx_sr_q   <= tx_sr_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      unr_q     <= unr_d;
    end
  end

  assign miso        = sel ? tx_sr_q[7] : 1'b1;
  assign miso_oe     = sel;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_vld_q;
  assign tx_ready    = ~full_q;
  assign crc         = crc_q;
  assign tx_underrun = unr_q;

endmodule
